// File: rtl/mips_mem_responder.sv
// Unified instruction/data memory responder for the MIPS_32 pipeline.
// Two requesters (I: fetch, D: load/store) share one single-ported word array.
// Conflicts alternate between the ports. Responses come out of a fixed-latency pipeline.
module mips_mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 2      // legal range 1..4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rsp_valid,
    output logic [31:0]       i_rsp_data,
    output logic              i_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        GrantI = 1'b0,
        GrantD = 1'b1
    } grant_e;

    logic [31:0] mem [DEPTH];

    grant_e last_grant_q, last_grant_d;

    logic              i_acc, d_acc, acc;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_err;
    logic [IDX_W-1:0]  sel_idx;
    logic              wr_en;
    logic [31:0]       rd_data;

    // Response pipeline: stage 0 is loaded at the accept edge, the last stage drives the outputs.
    logic [LATENCY-1:0] pv_q, pv_d;        // valid
    logic [LATENCY-1:0] pport_q, pport_d;  // 1 = D port
    logic [LATENCY-1:0] perr_q, perr_d;
    logic [31:0]        pdata_q [LATENCY];
    logic [31:0]        pdata_d [LATENCY];

    // Ready arbitration: hold blocks both, conflicts go to the port not granted last.
    // Ready is also held low during reset so nothing is accepted while rst_n is low.
    always_comb begin
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        if (rst_n && !hold) begin
            if (i_req_valid && d_req_valid) begin
                if (last_grant_q == GrantD) i_req_ready = 1'b1;
                else                        d_req_ready = 1'b1;
            end else if (d_req_valid) begin
                d_req_ready = 1'b1;
            end else begin
                i_req_ready = 1'b1;
            end
        end
    end

    // Select the single access for this cycle. Out-of-range addresses never touch the array.
    always_comb begin
        i_acc    = i_req_valid & i_req_ready;
        d_acc    = d_req_valid & d_req_ready;
        acc      = i_acc | d_acc;
        sel_addr = d_acc ? d_addr : i_addr;
        sel_err  = (sel_addr >= ADDR_W'(DEPTH));
        sel_idx  = sel_addr[IDX_W-1:0];
        wr_en    = d_acc & d_we & ~sel_err;
        rd_data  = '0;
        if (acc && !sel_err && !(d_acc && d_we)) rd_data = mem[sel_idx];
    end

    // Next-state for the grant history and the response shift register.
    always_comb begin
        last_grant_d = last_grant_q;
        if (i_acc)      last_grant_d = GrantI;
        else if (d_acc) last_grant_d = GrantD;

        pv_d[0]    = acc;
        pport_d[0] = d_acc;
        perr_d[0]  = acc & sel_err;
        pdata_d[0] = rd_data;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i]    = pv_q[i-1];
            pport_d[i] = pport_q[i-1];
            perr_d[i]  = perr_q[i-1];
            pdata_d[i] = pdata_q[i-1];
        end
    end

    // State registers; reset drops any in-flight responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GrantD;
            pv_q         <= '0;
            pport_q      <= '0;
            perr_q       <= '0;
            for (int i = 0; i < LATENCY; i++) pdata_q[i] <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            pv_q         <= pv_d;
            pport_q      <= pport_d;
            perr_q       <= perr_d;
            for (int i = 0; i < LATENCY; i++) pdata_q[i] <= pdata_d[i];
        end
    end

    // Memory array write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[sel_idx] <= d_wdata;
    end

    // Steer the last pipeline stage to the owning port; outputs are zero when not valid.
    always_comb begin
        i_rsp_valid = pv_q[LATENCY-1] & ~pport_q[LATENCY-1];
        d_rsp_valid = pv_q[LATENCY-1] & pport_q[LATENCY-1];
        i_rsp_err   = i_rsp_valid & perr_q[LATENCY-1];
        d_rsp_err   = d_rsp_valid & perr_q[LATENCY-1];
        i_rsp_data  = i_rsp_valid ? pdata_q[LATENCY-1] : 32'h0;
        d_rsp_data  = d_rsp_valid ? pdata_q[LATENCY-1] : 32'h0;
    end

endmodule
